// File: rtl/ucsbece154_mem_arbiter.sv
// Round-robin arbiter sharing the SDRAM read port between I-cache and D-cache refills.
// One requester owns the port for a full block burst, then a one-cycle gap precedes re-arbitration.
module ucsbece154_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IReq,
  input  logic [31:0]          IAddr,
  output logic                 IGrant,
  output logic [WORD_SIZE-1:0] IDataIn,
  output logic                 IDataReady,
  input  logic                 DReq,
  input  logic [31:0]          DAddr,
  output logic                 DGrant,
  output logic [WORD_SIZE-1:0] DDataIn,
  output logic                 DDataReady,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [WORD_SIZE-1:0] MemDataIn,
  input  logic                 MemDataReady
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int OFF   = 2 + CNT_W;
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t           state_q, state_d;
  logic             igrant_q, igrant_d;
  logic             dgrant_q, dgrant_d;
  logic             last_d_q, last_d_d;   // 1: D owned the most recent burst
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_i, pick_d;

  // On a tie, the side that did not own the previous burst wins.
  assign pick_i = IReq && (!DReq || last_d_q);
  assign pick_d = DReq && (!IReq || !last_d_q);

  always_comb begin
    state_d  = state_q;
    igrant_d = igrant_q;
    dgrant_d = dgrant_q;
    last_d_d = last_d_q;
    req_d    = req_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_i) begin
          igrant_d = 1'b1;
          last_d_d = 1'b0;
          req_d    = 1'b1;
          cnt_d    = '0;
          addr_d   = IAddr & ALIGN_MASK;
          state_d  = BURST;
        end else if (pick_d) begin
          dgrant_d = 1'b1;
          last_d_d = 1'b1;
          req_d    = 1'b1;
          cnt_d    = '0;
          addr_d   = DAddr & ALIGN_MASK;
          state_d  = BURST;
        end
      end
      BURST: begin
        if (MemDataReady) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            req_d    = 1'b0;
            igrant_d = 1'b0;
            dgrant_d = 1'b0;
            state_d  = GAP;
          end
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      igrant_q <= 1'b0;
      dgrant_q <= 1'b0;
      last_d_q <= 1'b1;
      req_q    <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      igrant_q <= igrant_d;
      dgrant_q <= dgrant_d;
      last_d_q <= last_d_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Grants are high exactly while a burst is in flight, so they gate forwarding directly.
  assign IGrant         = igrant_q;
  assign DGrant         = dgrant_q;
  assign IDataIn        = igrant_q ? MemDataIn : '0;
  assign DDataIn        = dgrant_q ? MemDataIn : '0;
  assign IDataReady     = igrant_q & MemDataReady;
  assign DDataReady     = dgrant_q & MemDataReady;
  assign MemReadRequest = req_q;
  assign MemReadAddress = addr_q;

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Directed bench for ucsbece154_mem_arbiter: per-cycle comparison against a burst-level
// ownership model, plus literal expectations at the key points of each scenario.
module tb_ucsbece154_mem_arbiter;
  localparam int BW = 4;

  logic        Clk = 1'b0;
  logic        Reset, IReq, DReq, MemDataReady;
  logic [31:0] IAddr, DAddr, MemDataIn;
  logic        IGrant, IDataReady, DGrant, DDataReady, MemReadRequest;
  logic [31:0] IDataIn, DDataIn, MemReadAddress;

  int checks = 0;
  int errors = 0;

  ucsbece154_mem_arbiter #(.BLOCK_WORDS(BW), .WORD_SIZE(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IGrant(IGrant), .IDataIn(IDataIn), .IDataReady(IDataReady),
    .DReq(DReq), .DAddr(DAddr), .DGrant(DGrant), .DDataIn(DDataIn), .DDataReady(DDataReady),
    .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
    .MemDataIn(MemDataIn), .MemDataReady(MemDataReady)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Model: who owns the port (0 none, 1 I, 2 D), beats still owed, idle cycles before arbitration.
  int          m_owner = 0;
  int          m_beats = 0;
  int          m_gap   = 0;
  int          m_last  = 2;
  logic [31:0] m_addr  = 32'h0;

  always @(posedge Clk) begin
    if (Reset) begin
      m_owner <= 0; m_beats <= 0; m_gap <= 0; m_last <= 2; m_addr <= 32'h0;
    end else if (m_owner != 0) begin
      if (MemDataReady) begin
        m_beats <= m_beats - 1;
        if (m_beats == 1) begin
          m_owner <= 0;
          m_gap   <= 1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap <= m_gap - 1;
    end else if (IReq && (!DReq || m_last == 2)) begin
      m_owner <= 1; m_last <= 1; m_beats <= BW;
      m_addr  <= (IAddr / 32'(4 * BW)) * 32'(4 * BW);
    end else if (DReq) begin
      m_owner <= 2; m_last <= 2; m_beats <= BW;
      m_addr  <= (DAddr / 32'(4 * BW)) * 32'(4 * BW);
    end
  end

  always @(negedge Clk) begin
    check("m_igrant", IGrant, 32'(m_owner == 1));
    check("m_dgrant", DGrant, 32'(m_owner == 2));
    check("m_memreq", MemReadRequest, 32'(m_owner != 0));
    check("m_addr", MemReadAddress, m_addr);
    check("m_idata", IDataIn, (m_owner == 1) ? MemDataIn : 32'h0);
    check("m_ddata", DDataIn, (m_owner == 2) ? MemDataIn : 32'h0);
    check("m_irdy", IDataReady, 32'((m_owner == 1) && MemDataReady));
    check("m_drdy", DDataReady, 32'((m_owner == 2) && MemDataReady));
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; IReq = 1'b0; DReq = 1'b0; IAddr = 32'h0; DAddr = 32'h0;
    MemDataIn = 32'h0; MemDataReady = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    tick();
    check("rst_memreq", MemReadRequest, 32'h0);
    check("rst_igrant", IGrant, 32'h0);
    check("rst_dgrant", DGrant, 32'h0);
    check("rst_addr", MemReadAddress, 32'h0);

    // Single I burst
    IReq = 1'b1; IAddr = 32'h0000_1234;
    tick();
    check("t1_igrant", IGrant, 32'h1);
    check("t1_memreq", MemReadRequest, 32'h1);
    check("t1_addr", MemReadAddress, 32'h0000_1230);
    for (int i = 0; i < 4; i++) begin
      MemDataIn = 32'hA0 + 32'(i); MemDataReady = 1'b1;
      #1;
      check("t1_idata", IDataIn, 32'hA0 + 32'(i));
      check("t1_irdy", IDataReady, 32'h1);
      tick();
      MemDataReady = 1'b0;
      if (i == 3) IReq = 1'b0;
    end
    check("t1_gap_memreq", MemReadRequest, 32'h0);
    check("t1_gap_igrant", IGrant, 32'h0);
    tick(); tick();
    check("t1_idle_igrant", IGrant, 32'h0);

    // Tie after reset: I first, then D, then I again
    Reset = 1'b1; IReq = 1'b1; DReq = 1'b1; IAddr = 32'h0000_2000; DAddr = 32'h8000_004C;
    tick();
    Reset = 1'b0;
    tick();
    check("t2_igrant", IGrant, 32'h1);
    check("t2_dgrant", DGrant, 32'h0);
    check("t2_addr", MemReadAddress, 32'h0000_2000);
    for (int i = 0; i < 4; i++) begin
      MemDataIn = 32'hB0 + 32'(i); MemDataReady = 1'b1;
      #1;
      check("t3_drdy", DDataReady, 32'h0);
      check("t3_ddata", DDataIn, 32'h0);
      check("t3_dgrant", DGrant, 32'h0);
      tick();
      MemDataReady = 1'b0;
      if (i == 3) IReq = 1'b0;
    end
    check("t2_gap_dgrant", DGrant, 32'h0);
    tick();
    check("t2_idle_dgrant", DGrant, 32'h0);
    tick();
    check("t2_dgrant_late", DGrant, 32'h1);
    check("t2_daddr", MemReadAddress, 32'h8000_0040);
    IReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MemDataIn = 32'hC0 + 32'(i); MemDataReady = 1'b1;
      #1;
      check("t2_ddata", DDataIn, 32'hC0 + 32'(i));
      check("t2_irdy_off", IDataReady, 32'h0);
      tick();
      MemDataReady = 1'b0;
    end
    tick(); tick();
    check("t2_tie3_igrant", IGrant, 32'h1);
    check("t2_tie3_dgrant", DGrant, 32'h0);
    DReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MemDataIn = 32'hC8 + 32'(i); MemDataReady = 1'b1;
      tick();
      MemDataReady = 1'b0;
      if (i == 3) IReq = 1'b0;
    end
    tick(); tick();

    // Stray beat in IDLE, then a burst whose owner drops IReq after beat 1
    MemDataIn = 32'h0000_DEAD; MemDataReady = 1'b1;
    #1;
    check("t4_irdy", IDataReady, 32'h0);
    check("t4_drdy", DDataReady, 32'h0);
    check("t4_idata", IDataIn, 32'h0);
    tick();
    MemDataReady = 1'b0;
    IReq = 1'b1; IAddr = 32'h0000_0044;
    tick();
    check("t4_igrant", IGrant, 32'h1);
    check("t4_addr", MemReadAddress, 32'h0000_0040);
    for (int i = 0; i < 4; i++) begin
      check("t6_memreq_hold", MemReadRequest, 32'h1);
      MemDataIn = 32'hE0 + 32'(i); MemDataReady = 1'b1;
      #1;
      check("t6_irdy", IDataReady, 32'h1);
      tick();
      MemDataReady = 1'b0;
      if (i == 0) IReq = 1'b0;
    end
    check("t6_memreq_done", MemReadRequest, 32'h0);
    tick(); tick();

    // Reset in the middle of a D burst
    DReq = 1'b1; DAddr = 32'h0000_0100;
    tick();
    check("t5_dgrant", DGrant, 32'h1);
    for (int i = 0; i < 2; i++) begin
      MemDataIn = 32'hF0 + 32'(i); MemDataReady = 1'b1;
      tick();
      MemDataReady = 1'b0;
    end
    Reset = 1'b1; IReq = 1'b1; DReq = 1'b1; MemDataIn = 32'h77; MemDataReady = 1'b1;
    tick();
    check("t5_memreq", MemReadRequest, 32'h0);
    check("t5_dgrant_off", DGrant, 32'h0);
    check("t5_late_drdy", DDataReady, 32'h0);
    MemDataReady = 1'b0; Reset = 1'b0;
    tick();
    check("t5_igrant", IGrant, 32'h1);
    check("t5_addr", MemReadAddress, 32'h0000_0040);
    Reset = 1'b1; IReq = 1'b0; DReq = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
